alu_issue_stage: RTL and testbench

- Decode/issue stage that drives the ALU operand interface (A, B, ALUFun, Sign) from a raw MIPS instruction word and register-file read data.
- Registered, single-entry ID/EX slot with valid/ready handshake and flush.
- Sits between the register-file read stage and the ALU in the MIPS pipeline.
- Produces the exact 6-bit ALUFun encoding that the ALU consumes.

---
 rtl/alu_issue_stage_if.sv | 34 +++
 rtl/alu_issue_stage.sv | 161 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Bus bundle for the ID/EX issue slot: upstream instruction/operand handshake
// on one side, ALU operand handshake on the other.
interface alu_issue_stage_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [31:0]      rs_data;
  logic [31:0]      rt_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [5:0]       alu_fun;
  logic             alu_sign;
  logic [4:0]       wr_reg;
  logic             wr_en;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output in_valid, instr, rs_data, rt_data, flush, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_fun, alu_sign,
           wr_reg, wr_en, illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, instr, rs_data, rt_data, flush, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_fun, alu_sign,
           wr_reg, wr_en, illegal, illegal_cnt
  );
endinterface

// File: rtl/alu_issue_stage.sv
// MIPS decode/issue stage: turns an instruction word plus register operands
// into a registered ALU operand slot (A, B, ALUFun, Sign) with handshake.
module alu_issue_stage #(
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             reset,
  alu_issue_stage_if.slave bus
);
  localparam logic [5:0] FUN_ADD = 6'b000000;
  localparam logic [5:0] FUN_SUB = 6'b000001;
  localparam logic [5:0] FUN_AND = 6'b011000;
  localparam logic [5:0] FUN_OR  = 6'b011110;
  localparam logic [5:0] FUN_XOR = 6'b010110;
  localparam logic [5:0] FUN_NOR = 6'b010001;
  localparam logic [5:0] FUN_SLL = 6'b100000;
  localparam logic [5:0] FUN_SRL = 6'b100001;
  localparam logic [5:0] FUN_SRA = 6'b100011;
  localparam logic [5:0] FUN_EQ  = 6'b110011;
  localparam logic [5:0] FUN_NEQ = 6'b110001;
  localparam logic [5:0] FUN_LT  = 6'b110101;
  localparam logic [5:0] FUN_LEZ = 6'b111101;
  localparam logic [5:0] FUN_LTZ = 6'b111011;
  localparam logic [5:0] FUN_GTZ = 6'b111111;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [5:0]  op, funct;
  logic [4:0]  rt, rd, shamt;
  logic [31:0] seImm, zeImm;

  assign op    = bus.instr[31:26];
  assign rt    = bus.instr[20:16];
  assign rd    = bus.instr[15:11];
  assign shamt = bus.instr[10:6];
  assign funct = bus.instr[5:0];
  assign seImm = {{16{bus.instr[15]}}, bus.instr[15:0]};
  assign zeImm = {16'b0, bus.instr[15:0]};

  logic [31:0]      aluA_d, aluA_q, aluB_d, aluB_q;
  logic [5:0]       aluFun_d, aluFun_q;
  logic             aluSign_d, aluSign_q;
  logic [4:0]       wrReg_d, wrReg_q;
  logic             wrEn_d, wrEn_q;
  logic             illegal_d, illegal_q;
  logic             valid_q;
  logic [CNT_W-1:0] illegalCnt_q;
  logic             legal, accept;

  always_comb begin
    aluA_d    = bus.rs_data;
    aluB_d    = '0;
    aluFun_d  = FUN_ADD;
    aluSign_d = 1'b0;
    wrReg_d   = rt;
    wrEn_d    = (rt != 5'd0);
    legal     = 1'b1;
    case (op)
      6'h00: begin
        aluB_d  = bus.rt_data;
        wrReg_d = rd;
        wrEn_d  = (rd != 5'd0);
        case (funct)
          6'h20: aluSign_d = 1'b1;
          6'h21: aluSign_d = 1'b0;
          6'h22: begin aluFun_d = FUN_SUB; aluSign_d = 1'b1; end
          6'h23: aluFun_d = FUN_SUB;
          6'h24: aluFun_d = FUN_AND;
          6'h25: aluFun_d = FUN_OR;
          6'h26: aluFun_d = FUN_XOR;
          6'h27: aluFun_d = FUN_NOR;
          6'h2A: begin aluFun_d = FUN_LT; aluSign_d = 1'b1; end
          6'h2B: aluFun_d = FUN_LT;
          6'h00: begin aluFun_d = FUN_SLL; aluA_d = {27'b0, shamt}; end
          6'h02: begin aluFun_d = FUN_SRL; aluA_d = {27'b0, shamt}; end
          6'h03: begin aluFun_d = FUN_SRA; aluA_d = {27'b0, shamt}; end
          default: legal = 1'b0;
        endcase
      end
      6'h08: begin aluB_d = seImm; aluSign_d = 1'b1; end
      6'h09: aluB_d = seImm;
      6'h0C: begin aluB_d = zeImm; aluFun_d = FUN_AND; end
      6'h0D: begin aluB_d = zeImm; aluFun_d = FUN_OR;  end
      6'h0E: begin aluB_d = zeImm; aluFun_d = FUN_XOR; end
      6'h0A: begin aluB_d = seImm; aluFun_d = FUN_LT; aluSign_d = 1'b1; end
      6'h0B: begin aluB_d = seImm; aluFun_d = FUN_LT; end
      6'h0F: begin aluA_d = 32'd16; aluB_d = zeImm; aluFun_d = FUN_SLL; end
      6'h23: aluB_d = seImm;
      6'h2B: begin aluB_d = seImm; wrReg_d = '0; wrEn_d = 1'b0; end
      6'h04, 6'h05, 6'h06, 6'h07, 6'h01: begin
        // Branches compare in signed mode and never write a register
        wrReg_d   = '0;
        wrEn_d    = 1'b0;
        aluSign_d = 1'b1;
        case (op)
          6'h04:   begin aluFun_d = FUN_EQ;  aluB_d = bus.rt_data; end
          6'h05:   begin aluFun_d = FUN_NEQ; aluB_d = bus.rt_data; end
          6'h06:   aluFun_d = FUN_LEZ;
          6'h07:   aluFun_d = FUN_GTZ;
          default: begin
            aluFun_d = FUN_LTZ;
            legal    = (rt == 5'd0);
          end
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      aluA_d    = '0;
      aluB_d    = '0;
      aluFun_d  = FUN_ADD;
      aluSign_d = 1'b0;
      wrReg_d   = '0;
      wrEn_d    = 1'b0;
    end
    illegal_d = !legal;
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

  // Flush only kills valid; payload registers hold so outputs stay quiet
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      aluA_q       <= '0;
      aluB_q       <= '0;
      aluFun_q     <= FUN_ADD;
      aluSign_q    <= 1'b0;
      wrReg_q      <= '0;
      wrEn_q       <= 1'b0;
      illegal_q    <= 1'b0;
      illegalCnt_q <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      aluA_q    <= aluA_d;
      aluB_q    <= aluB_d;
      aluFun_q  <= aluFun_d;
      aluSign_q <= aluSign_d;
      wrReg_q   <= wrReg_d;
      wrEn_q    <= wrEn_d;
      illegal_q <= illegal_d;
      if (illegal_d && illegalCnt_q != CNT_MAX)
        illegalCnt_q <= illegalCnt_q + 1'b1;
    end else if (bus.in_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.alu_a       = aluA_q;
  assign bus.alu_b       = aluB_q;
  assign bus.alu_fun     = aluFun_q;
  assign bus.alu_sign    = aluSign_q;
  assign bus.wr_reg      = wrReg_q;
  assign bus.wr_en       = wrEn_q;
  assign bus.illegal     = illegal_q;
  assign bus.illegal_cnt = illegalCnt_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed decode vectors from a table, followed by
// stall/flush, illegal-counter saturation and mid-stall reset sequences.
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_issue_stage_if #(.CNT_W(8)) bus ();

  alu_issue_stage #(.CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fun;
    logic        sign;
    logic [4:0]  wrReg;
    logic        wrEn;
    logic        ill;
  } vec_t;

  vec_t vecs[21];

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] rs,
                               input logic [31:0] rt, input logic inValid,
                               input logic outReady, input logic flush);
    bus.instr     = instr;
    bus.rs_data   = rs;
    bus.rt_data   = rt;
    bus.in_valid  = inValid;
    bus.out_ready = outReady;
    bus.flush     = flush;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, " alu_a"}, bus.alu_a, 32'd0);
    checkOutput({tag, " alu_b"}, bus.alu_b, 32'd0);
    checkOutput({tag, " alu_fun"}, 32'(bus.alu_fun), 32'd0);
    checkOutput({tag, " alu_sign"}, 32'(bus.alu_sign), 32'd0);
    checkOutput({tag, " wr_reg"}, 32'(bus.wr_reg), 32'd0);
    checkOutput({tag, " wr_en"}, 32'(bus.wr_en), 32'd0);
    checkOutput({tag, " illegal"}, 32'(bus.illegal), 32'd0);
    checkOutput({tag, " illegal_cnt"}, 32'(bus.illegal_cnt), 32'd0);
    checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    //              instr         rs            rt            a             b             fun     s  wr  en ill
    vecs[0]  = '{32'h00221820, 32'h00000007, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFFF, 6'h00, 1, 3, 1, 0};
    vecs[1]  = '{32'h000520C3, 32'h12345678, 32'h80000000, 32'h00000003, 32'h80000000, 6'h23, 0, 4, 1, 0};
    vecs[2]  = '{32'h3C061234, 32'hDEADBEEF, 32'h00000000, 32'h00000010, 32'h00001234, 6'h20, 0, 6, 1, 0};
    vecs[3]  = '{32'h2402FFFF, 32'h00000005, 32'h00000009, 32'h00000005, 32'hFFFFFFFF, 6'h00, 0, 2, 1, 0};
    vecs[4]  = '{32'h3002FFFF, 32'h00000005, 32'h00000009, 32'h00000005, 32'h0000FFFF, 6'h18, 0, 2, 1, 0};
    vecs[5]  = '{32'h10220004, 32'h00000003, 32'h00000004, 32'h00000003, 32'h00000004, 6'h33, 1, 0, 0, 0};
    vecs[6]  = '{32'h04200002, 32'h80000000, 32'h00000077, 32'h80000000, 32'h00000000, 6'h3B, 1, 0, 0, 0};
    vecs[7]  = '{32'h00221822, 32'h00000010, 32'h00000003, 32'h00000010, 32'h00000003, 6'h01, 1, 3, 1, 0};
    vecs[8]  = '{32'h00221827, 32'h000000F0, 32'h0000000F, 32'h000000F0, 32'h0000000F, 6'h11, 0, 3, 1, 0};
    vecs[9]  = '{32'h2822FFFE, 32'h00000001, 32'h00000000, 32'h00000001, 32'hFFFFFFFE, 6'h35, 1, 2, 1, 0};
    vecs[10] = '{32'hAC220008, 32'h00001000, 32'h00000055, 32'h00001000, 32'h00000008, 6'h00, 0, 0, 0, 0};
    vecs[11] = '{32'h00221801, 32'h00000007, 32'h00000008, 32'h00000000, 32'h00000000, 6'h00, 0, 0, 0, 1};
    vecs[12] = '{32'h04210002, 32'h00000007, 32'h00000008, 32'h00000000, 32'h00000000, 6'h00, 0, 0, 0, 1};
    vecs[13] = '{32'h20000005, 32'h00000002, 32'h00000003, 32'h00000002, 32'h00000005, 6'h00, 1, 0, 0, 0};
    vecs[14] = '{32'h38228000, 32'h00000001, 32'h00000000, 32'h00000001, 32'h00008000, 6'h16, 0, 2, 1, 0};
    vecs[15] = '{32'h0022182B, 32'h00000001, 32'h00000002, 32'h00000001, 32'h00000002, 6'h35, 0, 3, 1, 0};
    vecs[16] = '{32'h00021902, 32'h00000099, 32'hF0000000, 32'h00000004, 32'hF0000000, 6'h21, 0, 3, 1, 0};
    vecs[17] = '{32'h18200000, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 6'h3D, 1, 0, 0, 0};
    vecs[18] = '{32'h1C200000, 32'h00000042, 32'h00000005, 32'h00000042, 32'h00000000, 6'h3F, 1, 0, 0, 0};
    vecs[19] = '{32'h00221825, 32'h000000F0, 32'h0000000F, 32'h000000F0, 32'h0000000F, 6'h1E, 0, 3, 1, 0};
    vecs[20] = '{32'h8C22FFFC, 32'h00000100, 32'h00000000, 32'h00000100, 32'hFFFFFFFC, 6'h00, 0, 2, 1, 0};

    reset = 1'b1;
    applyStimulus(32'h00221820, 32'h1, 32'h2, 1'b1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkCleared("reset");
    reset = 1'b0;

    // Back-to-back issue: drive at negedge, result visible one edge later
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].rs, vecs[i].rt, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("vec%0d alu_a", i), bus.alu_a, vecs[i].a);
      checkOutput($sformatf("vec%0d alu_b", i), bus.alu_b, vecs[i].b);
      checkOutput($sformatf("vec%0d alu_fun", i), 32'(bus.alu_fun), 32'(vecs[i].fun));
      checkOutput($sformatf("vec%0d alu_sign", i), 32'(bus.alu_sign), 32'(vecs[i].sign));
      checkOutput($sformatf("vec%0d wr_reg", i), 32'(bus.wr_reg), 32'(vecs[i].wrReg));
      checkOutput($sformatf("vec%0d wr_en", i), 32'(bus.wr_en), 32'(vecs[i].wrEn));
      checkOutput($sformatf("vec%0d illegal", i), 32'(bus.illegal), 32'(vecs[i].ill));
      checkOutput($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'd1);
    end
    checkOutput("table illegal_cnt", 32'(bus.illegal_cnt), 32'd2);

    $display("[TB] stall and flush sequence");
    applyStimulus(32'h00221820, 32'h7, 32'h1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(32'h00221825, 32'hAA, 32'h55, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("stall in_ready comb", 32'(bus.in_ready), 32'd0);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checkOutput($sformatf("stall%0d out_valid", c), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("stall%0d in_ready", c), 32'(bus.in_ready), 32'd0);
      checkOutput($sformatf("stall%0d alu_a", c), bus.alu_a, 32'd7);
      checkOutput($sformatf("stall%0d alu_b", c), bus.alu_b, 32'd1);
      checkOutput($sformatf("stall%0d alu_fun", c), 32'(bus.alu_fun), 32'd0);
      checkOutput($sformatf("stall%0d wr_reg", c), 32'(bus.wr_reg), 32'd3);
    end
    applyStimulus(32'h00221825, 32'hAA, 32'h55, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("flush out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("flush alu_a hold", bus.alu_a, 32'd7);
    checkOutput("flush in_ready", 32'(bus.in_ready), 32'd1);
    applyStimulus(32'h00221825, 32'hAA, 32'h55, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("post-flush out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("post-flush alu_fun", 32'(bus.alu_fun), 32'd0);

    $display("[TB] flush with out_ready and illegal incoming");
    applyStimulus(32'h00221820, 32'h9, 32'h1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("preflush out_valid", 32'(bus.out_valid), 32'd1);
    applyStimulus(32'hFC000000, 32'h9, 32'h1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("flush+ready out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("flush+ready illegal", 32'(bus.illegal), 32'd0);
    checkOutput("flush+ready illegal_cnt", 32'(bus.illegal_cnt), 32'd2);

    $display("[TB] illegal counter saturation");
    for (int k = 1; k <= 260; k++) begin
      applyStimulus(32'hFC000000, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      if (k == 100)
        checkOutput("cnt after 100", 32'(bus.illegal_cnt), 32'd102);
      if (k == 253)
        checkOutput("cnt at max", 32'(bus.illegal_cnt), 32'd255);
    end
    checkOutput("sat illegal", 32'(bus.illegal), 32'd1);
    checkOutput("sat out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("sat alu_fun", 32'(bus.alu_fun), 32'd0);
    checkOutput("sat alu_a", bus.alu_a, 32'd0);
    checkOutput("sat alu_b", bus.alu_b, 32'd0);
    checkOutput("sat wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("sat illegal_cnt", 32'(bus.illegal_cnt), 32'd255);

    $display("[TB] reset during stall");
    applyStimulus(32'h00221820, 32'h7, 32'h1, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("stall before reset", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkCleared("midreset");
    reset = 1'b0;
    applyStimulus(32'h00221820, 32'h7, 32'h1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
